// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave register file.
//   Parameters: ADDR_WIDTH, DATA_WIDTH (32 or 64), NUM_REGS (power of 2, >= 2),
//               RO_MASK (bit i set: register i is read-only and reads from status_i).
//   Ports: ACLK/ARESETn; AW, W, B, AR and R AXI4-Lite channels;
//          regs_o   flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH];
//          status_i hardware values returned for read-only registers.
// The write and read paths are independent FSMs. AW and W are captured separately,
// in either order. The write commits on the edge where both are held.
module axi4_lite_regfile_slave #(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned Lsb   = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(NUM_REGS);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic {StWIdle, StWResp} w_state_e;
  typedef enum logic {StRIdle, StRData} r_state_e;

  // Any address bit at or above the register window makes the access out-of-range.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (Lsb + IdxW)) == '0;
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Write path state
  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]      wstrb_q, wstrb_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [IdxW-1:0]       widx;
  logic                  wr_err, commit;

  // Read path state
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [IdxW-1:0]       ridx;

  assign widx   = awaddr_q[Lsb +: IdxW];
  assign wr_err = !in_range(awaddr_q) || RO_MASK[widx];
  assign commit = (w_state_q == StWIdle) && aw_held_q && w_held_q;
  assign ridx   = ARADDR[Lsb +: IdxW];

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      StWIdle: begin
        if (AWVALID && awready_q) begin
          aw_held_d = 1'b1;
          awaddr_d  = AWADDR;
        end
        if (WVALID && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
        end
        if (commit) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_err ? RespSlvErr : RespOkay;
          w_state_d = StWResp;
        end
      end
      StWResp: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          bresp_d   = RespOkay;
          w_state_d = StWIdle;
        end
      end
      default: w_state_d = StWIdle;
    endcase
    // Readies are registered so they stay low in reset and rise one edge after release.
    awready_d = (w_state_d == StWIdle) && !aw_held_d;
    wready_d  = (w_state_d == StWIdle) && !w_held_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      StRIdle: begin
        if (ARVALID && arready_q) begin
          rvalid_d  = 1'b1;
          r_state_d = StRData;
          if (!in_range(ARADDR)) begin
            rdata_d = '0;
            rresp_d = RespSlvErr;
          end else begin
            rdata_d = RO_MASK[ridx] ? status_i[ridx*DATA_WIDTH +: DATA_WIDTH] : regs_q[ridx];
            rresp_d = RespOkay;
          end
        end
      end
      StRData: begin
        if (RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = StRIdle;
        end
      end
      default: r_state_d = StRIdle;
    endcase
    arready_d = (r_state_d == StRIdle);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= StWIdle;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      r_state_q <= StRIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit && !wr_err) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wstrb_q[b]) regs_q[widx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed, table-driven bench for axi4_lite_regfile_slave (32-bit data, 16 registers,
// register 2 read-only). Inputs are driven and outputs sampled on the falling edge.
module tb_axi4_lite_regfile_slave;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;
  localparam logic [NR-1:0] RoMask = 16'h0004;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic [AW-1:0]    AWADDR;
  logic             AWVALID, AWREADY;
  logic [DW-1:0]    WDATA;
  logic [DW/8-1:0]  WSTRB;
  logic             WVALID, WREADY;
  logic [1:0]       BRESP;
  logic             BVALID, BREADY;
  logic [AW-1:0]    ARADDR;
  logic             ARVALID, ARREADY;
  logic [DW-1:0]    RDATA;
  logic [1:0]       RRESP;
  logic             RVALID, RREADY;
  logic [NR*DW-1:0] regs_o;
  logic [NR*DW-1:0] status_i;

  axi4_lite_regfile_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RoMask)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o), .status_i(status_i)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] model [NR];
  int          n_vec = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s regs_o[%0d]", tag, i), regs_o[i*DW +: DW], model[i]);
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model[addr[5:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  // Starts on a falling edge. w_lead: cycles W is presented before AW.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead,
                          output logic [1:0] resp, output int lat);
    logic aw_now, w_now, awd, wd;
    int   t;
    awd = 1'b0; wd = 1'b0; t = 0;
    WVALID = 1'b1; WDATA = data; WSTRB = strb;
    if (w_lead == 0) begin AWVALID = 1'b1; AWADDR = addr; end
    while (!(awd && wd) && t < 50) begin
      aw_now = AWVALID && AWREADY;
      w_now  = WVALID && WREADY;
      @(negedge ACLK);
      t++;
      if (aw_now) begin AWVALID = 1'b0; awd = 1'b1; end
      if (w_now) begin WVALID = 1'b0; wd = 1'b1; end
      if (wd && !awd) check("wready low while aw pending", WREADY, 0);
      if (!awd && !AWVALID && t >= w_lead) begin AWVALID = 1'b1; AWADDR = addr; end
    end
    if (!(awd && wd)) begin
      check("write handshake timeout", 0, 1);
      AWVALID = 1'b0; WVALID = 1'b0; resp = 2'b11; lat = -1;
      return;
    end
    lat = 0;
    while (!BVALID && lat < 50) begin @(negedge ACLK); lat++; end
    resp = BRESP;
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int t;
    t = 0;
    ARVALID = 1'b1; ARADDR = addr;
    while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) check("arready timeout", 0, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    lat = 0;
    while (!RVALID && lat < 50) begin @(negedge ACLK); lat++; end
    data = RDATA; resp = RRESP;
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat;

    vecs[0]  = '{1'b1, 32'h04,   32'h12345678, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h04,   32'h0,        4'h0, 2'b00, 32'h12345678};
    vecs[2]  = '{1'b1, 32'h04,   32'hAABBCCDD, 4'h3, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 32'h04,   32'h0,        4'h0, 2'b00, 32'h1234CCDD};
    vecs[4]  = '{1'b1, 32'h40,   32'hDEADBEEF, 4'hF, 2'b10, 32'h0};
    vecs[5]  = '{1'b0, 32'h40,   32'h0,        4'h0, 2'b10, 32'h0};
    vecs[6]  = '{1'b1, 32'h08,   32'h11111111, 4'hF, 2'b10, 32'h0};
    vecs[7]  = '{1'b0, 32'h08,   32'h0,        4'h0, 2'b00, 32'hCAFE0001};
    vecs[8]  = '{1'b1, 32'h3C,   32'h0A0B0C0D, 4'hF, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, 32'h3F,   32'h0,        4'h0, 2'b00, 32'h0A0B0C0D};
    vecs[10] = '{1'b1, 32'h3C,   32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 32'h3C,   32'h0,        4'h0, 2'b00, 32'h0A0B0C0D};
    vecs[12] = '{1'b1, 32'h00,   32'hCAFEBABE, 4'hC, 2'b00, 32'h0};
    vecs[13] = '{1'b0, 32'h00,   32'h0,        4'h0, 2'b00, 32'hCAFE0000};
    vecs[14] = '{1'b0, 32'h1000, 32'h0,        4'h0, 2'b10, 32'h0};

    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    status_i = '0;
    for (int i = 0; i < NR; i++) status_i[i*DW +: DW] = 32'h5000_0000 + i;
    status_i[2*DW +: DW] = 32'hCAFE0001;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset state
    #1;
    check("reset AWREADY", AWREADY, 0);
    check("reset WREADY", WREADY, 0);
    check("reset ARREADY", ARREADY, 0);
    check("reset BVALID", BVALID, 0);
    check("reset RVALID", RVALID, 0);
    check("reset RDATA", RDATA, 0);
    check_regs("reset");
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    check("AWREADY before first edge", AWREADY, 0);
    @(negedge ACLK);
    check("AWREADY after first edge", AWREADY, 1);
    check("WREADY after first edge", WREADY, 1);
    check("ARREADY after first edge", ARREADY, 1);

    // Table-driven single transactions
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, resp, lat);
        check($sformatf("vec%0d BRESP", i), resp, vecs[i].resp);
        check($sformatf("vec%0d BVALID latency", i), lat, 1);
        if (vecs[i].resp == 2'b00) model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end else begin
        do_read(vecs[i].addr, rd, resp, lat);
        check($sformatf("vec%0d RRESP", i), resp, vecs[i].resp);
        check($sformatf("vec%0d RDATA", i), rd, vecs[i].rdata);
        check($sformatf("vec%0d RVALID latency", i), lat, 0);
      end
      check_regs($sformatf("vec%0d", i));
    end

    // W presented three cycles ahead of AW
    do_write(32'h14, 32'h55AA55AA, 4'hF, 3, resp, lat);
    check("w-first BRESP", resp, 2'b00);
    check("w-first BVALID latency", lat, 1);
    model_write(32'h14, 32'h55AA55AA, 4'hF);
    check_regs("w-first");
    do_read(32'h14, rd, resp, lat);
    check("w-first readback", rd, 32'h55AA55AA);

    // Back-pressure on B and R, then reset mid-burst
    AWVALID = 1'b1; AWADDR = 32'h18; WVALID = 1'b1; WDATA = 32'h0F0F0F0F; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 32'h04;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    @(negedge ACLK);
    model_write(32'h18, 32'h0F0F0F0F, 4'hF);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d BVALID", c), BVALID, 1);
      check($sformatf("bp%0d BRESP", c), BRESP, 2'b00);
      check($sformatf("bp%0d RVALID", c), RVALID, 1);
      check($sformatf("bp%0d RDATA", c), RDATA, 32'h1234CCDD);
      check($sformatf("bp%0d RRESP", c), RRESP, 2'b00);
      check($sformatf("bp%0d AWREADY", c), AWREADY, 0);
      check($sformatf("bp%0d WREADY", c), WREADY, 0);
      check($sformatf("bp%0d ARREADY", c), ARREADY, 0);
      @(negedge ACLK);
    end
    check_regs("bp");
    #2;
    ARESETn = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    check("midreset BVALID", BVALID, 0);
    check("midreset RVALID", RVALID, 0);
    check("midreset RDATA", RDATA, 0);
    check("midreset AWREADY", AWREADY, 0);
    check("midreset ARREADY", ARREADY, 0);
    check_regs("midreset");
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("post-reset AWREADY", AWREADY, 1);
    check("post-reset ARREADY", ARREADY, 1);
    do_read(32'h04, rd, resp, lat);
    check("post-reset read reg1", rd, 32'h0);
    check("post-reset RRESP", resp, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
